// File: rtl/key_entry_ctrl.sv
// Keypad entry controller: collects a two-digit charge amount, checks it against a limit,
// and holds the accepted value until the charger reports done.
module key_entry_ctrl #(
    parameter int unsigned MAX_AMOUNT  = 20,
    parameter int unsigned TIMEOUT_CYC = 500000000,
    parameter int unsigned TMR_W       = 29
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_value,
    input  logic       press_num,
    input  logic       start,
    input  logic       clear,
    input  logic       confirm,
    input  logic       done,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_lo,
    output logic [1:0] digit_cnt,
    output logic [6:0] amount,
    output logic       amount_valid,
    output logic       entry_active,
    output logic       locked,
    output logic       err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENTRY  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [6:0]       MAX_AMT  = 7'(MAX_AMOUNT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       hi_q, hi_d, lo_q, lo_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             is_digit;

    assign amount   = ({3'b000, hi_q} * 7'd10) + {3'b000, lo_q};
    assign is_digit = press_num && (key_value <= 4'd9);

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        timer_d = '0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ENTRY;
                    hi_d    = 4'd0;
                    lo_d    = 4'd0;
                    cnt_d   = 2'd0;
                end
            end
            ST_ENTRY: begin
                timer_d = timer_q + 1'b1;
                if (clear || start) begin
                    hi_d    = 4'd0;
                    lo_d    = 4'd0;
                    cnt_d   = 2'd0;
                    timer_d = '0;
                end else if (confirm) begin
                    timer_d = '0;
                    if (cnt_q != 2'd0) begin
                        if ((amount == 7'd0) || (amount > MAX_AMT)) begin
                            err_d = 1'b1;
                            hi_d  = 4'd0;
                            lo_d  = 4'd0;
                            cnt_d = 2'd0;
                        end else begin
                            state_d = ST_LOCKED;
                            valid_d = 1'b1;
                        end
                    end
                end else if (is_digit) begin
                    timer_d = '0;
                    // Digits shift in from the right; a third digit is dropped.
                    if (cnt_q == 2'd0) begin
                        lo_d  = key_value;
                        cnt_d = 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        hi_d  = lo_q;
                        lo_d  = key_value;
                        cnt_d = 2'd2;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d = ST_IDLE;
                    hi_d    = 4'd0;
                    lo_d    = 4'd0;
                    cnt_d   = 2'd0;
                    timer_d = '0;
                end
            end
            ST_LOCKED: begin
                if (done || clear) begin
                    state_d = ST_IDLE;
                    hi_d    = 4'd0;
                    lo_d    = 4'd0;
                    cnt_d   = 2'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hi_d    = 4'd0;
                lo_d    = 4'd0;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hi_q    <= 4'd0;
            lo_q    <= 4'd0;
            cnt_q   <= 2'd0;
            timer_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign digit_hi     = hi_q;
    assign digit_lo     = lo_q;
    assign digit_cnt    = cnt_q;
    assign amount_valid = valid_q;
    assign err          = err_q;
    assign entry_active = (state_q == ST_ENTRY);
    assign locked       = (state_q == ST_LOCKED);

endmodule
